// File: rtl/ti_tile_sched.sv
// Tile scheduler: walks the TI tile buffer, fetches tile entries and
// deals non-empty tiles to the raster slices in round-robin order.
module ti_tile_sched #(
  parameter int NUM_SLICES  = 4,
  parameter int ADDR_BITS   = 32,
  parameter int TILE_BITS   = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  tbuf_addr,
  input  logic [TILE_BITS-1:0]  tile_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_BITS-1:0]  mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [63:0]           mem_rsp_data,
  output logic [NUM_SLICES-1:0] slice_valid,
  input  logic [NUM_SLICES-1:0] slice_ready,
  output logic [15:0]           tile_x,
  output logic [15:0]           tile_y,
  output logic [15:0]           pid_offset,
  output logic [15:0]           pid_count
);

  localparam int RW    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int PW    = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CW    = $clog2(MAX_PENDING + 1);
  localparam int DEPTH = 1 << PW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] base;
  logic [TILE_BITS-1:0] count;
  logic [TILE_BITS-1:0] issued;
  logic [TILE_BITS-1:0] retired;
  logic [CW-1:0]        credits;
  logic [RW-1:0]        rr_ptr;
  logic [RW-1:0]        rr_next;

  logic [63:0]          fifo_mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [63:0]          head;

  logic push;
  logic pop;
  logic skip;
  logic offer;
  logic dispatch;
  logic req_fire;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(MAX_PENDING));
  assign head       = fifo_empty ? '0 : fifo_mem[rd_ptr];

  assign busy = (state != IDLE);

  assign mem_req_valid = (state == FETCH) &&
                         (issued < count) &&
                         (credits < CW'(MAX_PENDING));
  assign mem_req_addr  = base + (ADDR_BITS'(issued) << 3);
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses outside a job belong to a flushed job and are dropped.
  assign push = mem_rsp_valid && (state != IDLE);

  assign skip     = !fifo_empty && (head[63:48] == '0);
  assign offer    = !fifo_empty && (head[63:48] != '0);
  assign dispatch = offer && slice_ready[rr_ptr];
  assign pop      = skip || dispatch;

  assign slice_valid = offer ? (NUM_SLICES'(1) << rr_ptr) : '0;
  assign pid_count   = head[63:48];
  assign pid_offset  = head[47:32];
  assign tile_y      = head[31:16];
  assign tile_x      = head[15:0];

  assign rr_next = (rr_ptr == RW'(NUM_SLICES - 1)) ?
                   '0 : rr_ptr + RW'(1);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rsp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      base    <= '0;
      count   <= '0;
      issued  <= '0;
      retired <= '0;
      credits <= '0;
      rr_ptr  <= '0;
    end else begin
      done    <= 1'b0;
      credits <= credits + CW'(req_fire) - CW'(pop);
      if (req_fire) issued  <= issued + TILE_BITS'(1);
      if (pop)      retired <= retired + TILE_BITS'(1);
      if (dispatch) rr_ptr  <= rr_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (tile_count == '0) begin
              done <= 1'b1;
            end else begin
              state   <= FETCH;
              base    <= tbuf_addr;
              count   <= tile_count;
              issued  <= '0;
              retired <= '0;
            end
          end
        end
        FETCH: begin
          if (req_fire && (issued + TILE_BITS'(1) == count))
            state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (retired + TILE_BITS'(1) == count)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credits bound outstanding plus buffered entries to the FIFO depth.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset) push |-> !fifo_full
  );

endmodule

// File: tb/tb_ti_tile_sched.sv
// Scoreboard bench for ti_tile_sched: 1-cycle memory model,
// expected addresses and slice dispatches queued at job start.
module tb_ti_tile_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] tbuf_addr;
  logic [15:0] tile_count;
  logic        busy;
  logic        done;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [3:0]  slice_valid;
  logic [3:0]  slice_ready;
  logic [15:0] tile_x;
  logic [15:0] tile_y;
  logic [15:0] pid_offset;
  logic [15:0] pid_count;

  ti_tile_sched dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .tbuf_addr     (tbuf_addr),
    .tile_count    (tile_count),
    .busy          (busy),
    .done          (done),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .slice_valid   (slice_valid),
    .slice_ready   (slice_ready),
    .tile_x        (tile_x),
    .tile_y        (tile_y),
    .pid_offset    (pid_offset),
    .pid_count     (pid_count)
  );

  int n_cmp;
  int n_bad;
  int n_req;
  int n_disp;
  int rr_m;

  logic        mreq_en;
  logic [3:0]  sready_mask;
  logic [63:0] mem_a [logic [31:0]];
  logic [31:0] exp_addr [$];
  int          exp_slc [$];
  logic [63:0] exp_dat [$];
  logic [63:0] rspq [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model and output monitor, all decisions mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      rspq.delete();
    end else begin
      mem_req_ready = mreq_en;
      slice_ready   = sready_mask;
      if (rspq.size() > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rspq.pop_front();
      end else begin
        mem_rsp_valid = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        n_req++;
        if (exp_addr.size() == 0)
          chk("req_extra", {32'h0, mem_req_addr}, 64'h0);
        else
          chk("req_addr", {32'h0, mem_req_addr},
              {32'h0, exp_addr.pop_front()});
        if (mem_a.exists(mem_req_addr))
          rspq.push_back(mem_a[mem_req_addr]);
        else
          rspq.push_back(64'h0);
      end
      if (|(slice_valid & slice_ready)) begin
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++)
          if (slice_valid[i]) idx = i;
        n_disp++;
        chk("disp_onehot", {63'h0, $onehot(slice_valid)}, 64'h1);
        if (exp_slc.size() == 0) begin
          chk("disp_extra", 64'(idx), 64'hffff);
        end else begin
          chk("disp_slice", 64'(idx), 64'(exp_slc.pop_front()));
          chk("disp_data", {pid_count, pid_offset, tile_y, tile_x},
              exp_dat.pop_front());
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] b, input int n,
                           input logic [15:0] zmask);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [63:0] d;
      a = b + 32'(i * 8);
      d = {(zmask[i] ? 16'h0 : 16'(i + 1)), 16'($urandom),
           16'($urandom), 16'($urandom)};
      mem_a[a] = d;
      exp_addr.push_back(a);
      if (d[63:48] != 16'h0) begin
        exp_slc.push_back(rr_m);
        exp_dat.push_back(d);
        rr_m = (rr_m + 1) % 4;
      end
    end
    tbuf_addr  = b;
    tile_count = 16'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", {63'h0, busy}, 64'h1);
    chk("start_req", {63'h0, mem_req_valid}, {63'h0, mreq_en});
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done"}, {63'h0, seen}, 64'h1);
    chk({tag, "_idle"}, {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {63'h0, done}, 64'h0);
    chk({tag, "_addrq"}, 64'(exp_addr.size()), 64'h0);
    chk({tag, "_dispq"}, 64'(exp_slc.size()), 64'h0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
    chk({tag, "_done"}, {63'h0, done}, 64'h0);
    chk({tag, "_req"}, {63'h0, mem_req_valid}, 64'h0);
    chk({tag, "_addr"}, {32'h0, mem_req_addr}, 64'h0);
    chk({tag, "_sv"}, {60'h0, slice_valid}, 64'h0);
    chk({tag, "_pay"}, {pid_count, pid_offset, tile_y, tile_x}, 64'h0);
  endtask

  initial begin
    int r0;
    n_cmp = 0;
    n_bad = 0;
    n_req = 0;
    n_disp = 0;
    rr_m = 0;
    reset = 1'b0;
    start = 1'b0;
    tbuf_addr = '0;
    tile_count = '0;
    mreq_en = 1'b1;
    sready_mask = 4'hf;
    mem_req_ready = 1'b0;
    slice_ready = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Empty job: done only, no fetches.
    tbuf_addr = 32'h500;
    tile_count = 16'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", {63'h0, done}, 64'h1);
    chk("zero_busy", {63'h0, busy}, 64'h0);
    chk("zero_req", {63'h0, mem_req_valid}, 64'h0);
    @(posedge clk); #1;
    chk("zero_pulse", {63'h0, done}, 64'h0);
    chk("zero_nreq", 64'(n_req), 64'h0);

    start_job(32'h1000, 3, 16'h0);
    wait_done("basic");

    start_job(32'h3000, 3, 16'h5);
    wait_done("skip");

    // Credit limit with every slice stalled.
    sready_mask = 4'h0;
    r0 = n_req;
    start_job(32'h4000, 8, 16'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_nreq", 64'(n_req - r0), 64'h4);
    chk("stall_req", {63'h0, mem_req_valid}, 64'h0);
    sready_mask = 4'h1;
    repeat (20) @(posedge clk);
    #1;
    chk("credit_nreq", 64'(n_req - r0), 64'h5);
    sready_mask = 4'hf;
    wait_done("stall");

    // Two back-to-back jobs, stray start mid-job.
    start_job(32'h5000, 6, 16'h0);
    @(posedge clk); #1;
    tbuf_addr = 32'h9000;
    tile_count = 16'h5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("job6");
    start_job(32'h6000, 2, 16'h0);
    wait_done("job2");

    // Address wrap, then reset after the first dispatch.
    r0 = n_disp;
    start_job(32'hFFFFFFF8, 2, 16'h0);
    for (int c = 0; c < 100 && n_disp == r0; c++) begin
      @(posedge clk); #1;
    end
    chk("wrap_disp", 64'(n_disp - r0), 64'h1);
    chk("wrap_addrq", 64'(exp_addr.size()), 64'h0);
    reset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    exp_slc.delete();
    exp_dat.delete();
    rr_m = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    start_job(32'h2000, 2, 16'h0);
    wait_done("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
